exmem_elastic_reg: RTL

- Parametrised EX/MEM pipeline register for the RISC-V core, replacing the fixed always-load stage register.
- Carries PC+4, store data, ALU result, destination register and control bits (regWrite, MemWrite, Resultsrc).
- Adds a valid/ready handshake, an optional 2-entry skid buffer, synchronous flush (bubble insertion), x0-write suppression and a forwarding tap for the hazard unit.

---
 rtl/exmem_elastic_reg.sv | 119 +++++++++++
 1 files changed

// File: rtl/exmem_elastic_reg.sv
// EX/MEM elastic pipeline register with valid/ready handshake,
// optional two-entry skid buffer, flush, x0 gating and forwarding tap.
module exmem_elastic_reg #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REGADDR_W = 5,
    parameter int unsigned RESSRC_W  = 2,
    parameter bit          SKID_EN   = 1'b1,
    parameter bit          ZERO_X0   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      PCplus4,
    input  logic [XLEN-1:0]      Port_B,
    input  logic [XLEN-1:0]      ALU_Out,
    input  logic [REGADDR_W-1:0] dest_reg,
    input  logic                 regWrite,
    input  logic                 MemWrite,
    input  logic [RESSRC_W-1:0]  Resultsrc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      PCplus41,
    output logic [XLEN-1:0]      Port_B1,
    output logic [XLEN-1:0]      ALU_Out1,
    output logic [REGADDR_W-1:0] dest_reg1,
    output logic                 regWrite1,
    output logic                 MemWrite1,
    output logic [RESSRC_W-1:0]  Resultsrc1,
    output logic                 fwd_valid,
    output logic [REGADDR_W-1:0] fwd_rd,
    output logic [XLEN-1:0]      fwd_data
);

    localparam int unsigned W = 3 * XLEN + REGADDR_W + 2 + RESSRC_W;

    logic [W-1:0] in_data;
    logic [W-1:0] m_data_q, m_data_d;
    logic [W-1:0] s_data_q, s_data_d;
    logic         m_valid_q, m_valid_d;
    logic         s_valid_q, s_valid_d;
    logic         rdy_q, rdy_d;
    logic         rw_cap;
    logic         acc;
    logic         cons;

    always_comb begin
        rw_cap  = regWrite & ((|dest_reg) | ~ZERO_X0);
        in_data = {PCplus4, Port_B, ALU_Out, dest_reg,
                   rw_cap, MemWrite, Resultsrc};
    end

    // Skid mode: ready is a flop so out_ready never reaches in_ready.
    assign in_ready = SKID_EN ? rdy_q
                              : (rdy_q & (~m_valid_q | out_ready));
    assign acc  = in_valid & in_ready;
    assign cons = m_valid_q & out_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        if (flush) begin
            m_valid_d = 1'b0;
            m_data_d  = '0;
            s_valid_d = 1'b0;
            s_data_d  = '0;
        end else if (cons) begin
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_data_d  = s_data_q;
                s_valid_d = acc;
                s_data_d  = acc ? in_data : '0;
            end else if (acc) begin
                m_valid_d = 1'b1;
                m_data_d  = in_data;
            end else begin
                m_valid_d = 1'b0;
                m_data_d  = '0;
            end
        end else if (acc) begin
            if (!m_valid_q) begin
                m_valid_d = 1'b1;
                m_data_d  = in_data;
            end else if (SKID_EN) begin
                s_valid_d = 1'b1;
                s_data_d  = in_data;
            end
        end
        rdy_d = SKID_EN ? ~s_valid_d : 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
            rdy_q     <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
            rdy_q     <= rdy_d;
        end
    end

    assign out_valid = m_valid_q;
    assign {PCplus41, Port_B1, ALU_Out1, dest_reg1,
            regWrite1, MemWrite1, Resultsrc1} = m_data_q;

    assign fwd_valid = m_valid_q & regWrite1 & (|dest_reg1);
    assign fwd_rd    = dest_reg1;
    assign fwd_data  = ALU_Out1;

endmodule
